id_ex_pipeline_reg: RTL and testbench
=====================================

// Module: id_ex_pipeline_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage RV64 pipeline. Captures decoded operands, immediate,
//  register indices and control bits from ID. Presents them to EX, which feeds the forwarding
//  muxes and the forwarding unit. Supports stall (hold), flush (bubble insert) and WB-to-ID bypass,
//  so an operand read in the same cycle as its writeback (or while held) is never stale.
// PARAMETERS
//  XLEN     64   operand/PC/immediate width
//  REG_AW   5    register index width
// PORTS
//  clk                  in   1       rising-edge clock
//  reset                in   1       asynchronous, active-high reset
//  stall                in   1       hold all ID_EX_* contents this cycle
//  flush                in   1       load a bubble this cycle
//  IF_ID_pc             in   XLEN    PC of instruction in ID
//  rs1_value/rs2_value  in   XLEN    register-file read data (signed)
//  imm                  in   XLEN    sign-extended immediate
//  rs1/rs2/rd           in   REG_AW  register indices from decode
//  funct                in   4       {funct7[5], funct3}
//  RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch  in 1 each  decoded controls
//  ALUOp                in   2       ALU control class
//  MEM_WB_RegWrite      in   1       WB stage writes register file
//  MEM_WB_rd            in   REG_AW  WB destination
//  writeback_mux_value  in   XLEN    WB data (signed)
//  ID_EX_valid          out  1       slot holds a real instruction
//  ID_EX_pc, ID_EX_rs1_value, ID_EX_rs2_value, ID_EX_imm  out XLEN  registered copies
//  ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out REG_AW;  ID_EX_funct out 4
//  ID_EX_RegWrite..ID_EX_Branch out 1 each;  ID_EX_ALUOp out 2
// BEHAVIOUR
//  - Reset (async, active-high): every output 0, including ID_EX_valid. Reset asserted mid-operation
//    clears the slot immediately. No pending state survives.
//  - Priority per rising edge: reset > flush > stall > load.
//  - Load: all outputs <= ID inputs on the next edge (latency 1 cycle); ID_EX_valid <= 1.
//  - Flush: ID_EX_valid, RegWrite, MemRead, MemWrite, Branch, ALUOp <= 0; rd/rs1/rs2 <= 0, so the
//    bubble never matches a forwarding or hazard compare. Other data fields are don't-care; drive 0.
//    Flush with stall high still inserts the bubble.
//  - Stall: all fields hold, except the operand refresh below.
//  - WB bypass on load: rs1_value is captured as writeback_mux_value when MEM_WB_RegWrite=1,
//    MEM_WB_rd!=0 and MEM_WB_rd==rs1; otherwise rs1_value is captured. Same rule for rs2.
//  - Operand refresh on stall: while stall=1 and ID_EX_valid=1, if MEM_WB_RegWrite=1,
//    MEM_WB_rd!=0 and MEM_WB_rd==ID_EX_rs1, ID_EX_rs1_value <= writeback_mux_value. Same rule for rs2.
//    This covers a producer retiring while its consumer is held.
//  - x0: index 0 never bypasses or refreshes; the captured rs*_value passes through unchanged.
//  - Arithmetic: none; all values pass bit-exact. The WB compare is an unsigned REG_AW-bit equality.
//  - Purely registered outputs: no combinational input-to-output path.
// TESTING
//  1 reset=1 mid-stream with valid slot -> all outputs 0 immediately, before next clk edge.
//  2 load rs1=5,rs1_value=10, MEM_WB_RegWrite=1,MEM_WB_rd=5,wb=-7 -> ID_EX_rs1_value=-7 next cycle;
//    repeat with MEM_WB_rd=0, rs1=0 -> captured value 10.
//  3 valid slot (RegWrite=1,rd=3), assert flush -> valid=0,RegWrite=0,rd=0; flush+stall together -> same.
//  4 stall 3 cycles with changing ID inputs -> outputs unchanged; then release -> new ID values after 1 edge.
//  5 stall with ID_EX_rs2=8 while WB writes x8=0x1234 -> ID_EX_rs2_value=0x1234, all other fields held.
//  6 back-to-back loads of 4 instructions -> each appears on ID_EX_* exactly 1 cycle later, valid=1.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded operands and controls from ID, with stall, flush
// and WB-to-ID bypass so a held or freshly read operand never goes stale.
module id_ex_pipeline_reg #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [XLEN-1:0]   IF_ID_pc,
    input  logic [XLEN-1:0]   rs1_value,
    input  logic [XLEN-1:0]   rs2_value,
    input  logic [XLEN-1:0]   imm,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        funct,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              ALUSrc,
    input  logic              Branch,
    input  logic [1:0]        ALUOp,
    input  logic              MEM_WB_RegWrite,
    input  logic [REG_AW-1:0] MEM_WB_rd,
    input  logic [XLEN-1:0]   writeback_mux_value,
    output logic              ID_EX_valid,
    output logic [XLEN-1:0]   ID_EX_pc,
    output logic [XLEN-1:0]   ID_EX_rs1_value,
    output logic [XLEN-1:0]   ID_EX_rs2_value,
    output logic [XLEN-1:0]   ID_EX_imm,
    output logic [REG_AW-1:0] ID_EX_rs1,
    output logic [REG_AW-1:0] ID_EX_rs2,
    output logic [REG_AW-1:0] ID_EX_rd,
    output logic [3:0]        ID_EX_funct,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemtoReg,
    output logic              ID_EX_ALUSrc,
    output logic              ID_EX_Branch,
    output logic [1:0]        ID_EX_ALUOp
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_value;
        logic [XLEN-1:0]   rs2_value;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [3:0]        funct;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              memto_reg;
        logic              alu_src;
        logic              branch;
        logic [1:0]        alu_op;
    } slot_t;

    slot_t slot_d, slot_q;

    logic wb_active;
    logic load_hit_rs1, load_hit_rs2;
    logic hold_hit_rs1, hold_hit_rs2;

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    assign wb_active    = MEM_WB_RegWrite && (MEM_WB_rd != '0);
    assign load_hit_rs1 = wb_active && (MEM_WB_rd == rs1);
    assign load_hit_rs2 = wb_active && (MEM_WB_rd == rs2);
    assign hold_hit_rs1 = wb_active && slot_q.valid && (MEM_WB_rd == slot_q.rs1);
    assign hold_hit_rs2 = wb_active && slot_q.valid && (MEM_WB_rd == slot_q.rs2);

    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            // Zeroed indices keep the bubble out of every forwarding/hazard compare.
            slot_d = '0;
        end else if (stall) begin
            if (hold_hit_rs1) slot_d.rs1_value = writeback_mux_value;
            if (hold_hit_rs2) slot_d.rs2_value = writeback_mux_value;
        end else begin
            slot_d.valid     = 1'b1;
            slot_d.pc        = IF_ID_pc;
            slot_d.rs1_value = load_hit_rs1 ? writeback_mux_value : rs1_value;
            slot_d.rs2_value = load_hit_rs2 ? writeback_mux_value : rs2_value;
            slot_d.imm       = imm;
            slot_d.rs1       = rs1;
            slot_d.rs2       = rs2;
            slot_d.rd        = rd;
            slot_d.funct     = funct;
            slot_d.reg_write = RegWrite;
            slot_d.mem_read  = MemRead;
            slot_d.mem_write = MemWrite;
            slot_d.memto_reg = MemtoReg;
            slot_d.alu_src   = ALUSrc;
            slot_d.branch    = Branch;
            slot_d.alu_op    = ALUOp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign ID_EX_valid     = slot_q.valid;
    assign ID_EX_pc        = slot_q.pc;
    assign ID_EX_rs1_value = slot_q.rs1_value;
    assign ID_EX_rs2_value = slot_q.rs2_value;
    assign ID_EX_imm       = slot_q.imm;
    assign ID_EX_rs1       = slot_q.rs1;
    assign ID_EX_rs2       = slot_q.rs2;
    assign ID_EX_rd        = slot_q.rd;
    assign ID_EX_funct     = slot_q.funct;
    assign ID_EX_RegWrite  = slot_q.reg_write;
    assign ID_EX_MemRead   = slot_q.mem_read;
    assign ID_EX_MemWrite  = slot_q.mem_write;
    assign ID_EX_MemtoReg  = slot_q.memto_reg;
    assign ID_EX_ALUSrc    = slot_q.alu_src;
    assign ID_EX_Branch    = slot_q.branch;
    assign ID_EX_ALUOp     = slot_q.alu_op;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed, table-driven bench for id_ex_pipeline_reg: loads, bypass, flush, stall/refresh,
// plus hand-written reset sequences.
module tb_id_ex_pipeline_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [63:0] IF_ID_pc, rs1_value, rs2_value, imm, writeback_mux_value;
    logic [4:0]  rs1, rs2, rd, MEM_WB_rd;
    logic [3:0]  funct;
    logic [7:0]  ctl;
    logic        MEM_WB_RegWrite;

    logic        ID_EX_valid;
    logic [63:0] ID_EX_pc, ID_EX_rs1_value, ID_EX_rs2_value, ID_EX_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [3:0]  ID_EX_funct;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
    logic        ID_EX_ALUSrc, ID_EX_Branch;
    logic [1:0]  ID_EX_ALUOp;
    logic [7:0]  out_ctl;

    assign out_ctl = {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
                      ID_EX_ALUSrc, ID_EX_Branch, ID_EX_ALUOp};

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(.XLEN(64), .REG_AW(5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .flush               (flush),
        .IF_ID_pc            (IF_ID_pc),
        .rs1_value           (rs1_value),
        .rs2_value           (rs2_value),
        .imm                 (imm),
        .rs1                 (rs1),
        .rs2                 (rs2),
        .rd                  (rd),
        .funct               (funct),
        .RegWrite            (ctl[7]),
        .MemRead             (ctl[6]),
        .MemWrite            (ctl[5]),
        .MemtoReg            (ctl[4]),
        .ALUSrc              (ctl[3]),
        .Branch              (ctl[2]),
        .ALUOp               (ctl[1:0]),
        .MEM_WB_RegWrite     (MEM_WB_RegWrite),
        .MEM_WB_rd           (MEM_WB_rd),
        .writeback_mux_value (writeback_mux_value),
        .ID_EX_valid         (ID_EX_valid),
        .ID_EX_pc            (ID_EX_pc),
        .ID_EX_rs1_value     (ID_EX_rs1_value),
        .ID_EX_rs2_value     (ID_EX_rs2_value),
        .ID_EX_imm           (ID_EX_imm),
        .ID_EX_rs1           (ID_EX_rs1),
        .ID_EX_rs2           (ID_EX_rs2),
        .ID_EX_rd            (ID_EX_rd),
        .ID_EX_funct         (ID_EX_funct),
        .ID_EX_RegWrite      (ID_EX_RegWrite),
        .ID_EX_MemRead       (ID_EX_MemRead),
        .ID_EX_MemWrite      (ID_EX_MemWrite),
        .ID_EX_MemtoReg      (ID_EX_MemtoReg),
        .ID_EX_ALUSrc        (ID_EX_ALUSrc),
        .ID_EX_Branch        (ID_EX_Branch),
        .ID_EX_ALUOp         (ID_EX_ALUOp)
    );

    typedef struct {
        string       name;
        logic        stall, flush;
        logic [63:0] pc, v1, v2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [7:0]  ctl;
        logic [3:0]  funct;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [63:0] wbval;
        logic        e_valid;
        logic [63:0] e_pc, e_v1, e_v2, e_imm;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic [7:0]  e_ctl;
        logic [3:0]  e_funct;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 64'(ID_EX_valid), 64'd0);
        chk({tag, ".pc"}, ID_EX_pc, 64'd0);
        chk({tag, ".v1"}, ID_EX_rs1_value, 64'd0);
        chk({tag, ".v2"}, ID_EX_rs2_value, 64'd0);
        chk({tag, ".imm"}, ID_EX_imm, 64'd0);
        chk({tag, ".idx"}, 64'({ID_EX_rs1, ID_EX_rs2, ID_EX_rd}), 64'd0);
        chk({tag, ".ctl"}, 64'({out_ctl, ID_EX_funct}), 64'd0);
    endtask

    // Generic record: ID inputs plus hand-written expected slot contents.
    task automatic add(input string nm, input logic st, input logic fl,
                       input logic [63:0] pc, input logic [4:0] r1, input logic [63:0] v1,
                       input logic [4:0] r2, input logic [63:0] v2, input logic [4:0] d,
                       input logic [63:0] im, input logic [7:0] c, input logic [3:0] f,
                       input logic we, input logic [4:0] wrd, input logic [63:0] wv,
                       input logic ev, input logic [63:0] epc, input logic [4:0] er1,
                       input logic [63:0] ev1, input logic [4:0] er2, input logic [63:0] ev2,
                       input logic [4:0] erd, input logic [63:0] eim, input logic [7:0] ec,
                       input logic [3:0] ef);
        vec_t v;
        v.name = nm; v.stall = st; v.flush = fl; v.pc = pc; v.rs1 = r1; v.v1 = v1;
        v.rs2 = r2; v.v2 = v2; v.rd = d; v.imm = im; v.ctl = c; v.funct = f;
        v.wbwe = we; v.wbrd = wrd; v.wbval = wv;
        v.e_valid = ev; v.e_pc = epc; v.e_rs1 = er1; v.e_v1 = ev1; v.e_rs2 = er2;
        v.e_v2 = ev2; v.e_rd = erd; v.e_imm = eim; v.e_ctl = ec; v.e_funct = ef;
        vecs.push_back(v);
    endtask

    // Plain load: every field passes through, operand values given explicitly.
    task automatic add_load(input string nm, input logic [63:0] pc, input logic [4:0] r1,
                            input logic [63:0] v1, input logic [4:0] r2, input logic [63:0] v2,
                            input logic [4:0] d, input logic [63:0] im, input logic [7:0] c,
                            input logic [3:0] f, input logic we, input logic [4:0] wrd,
                            input logic [63:0] wv, input logic [63:0] ev1,
                            input logic [63:0] ev2);
        add(nm, 1'b0, 1'b0, pc, r1, v1, r2, v2, d, im, c, f, we, wrd, wv,
            1'b1, pc, r1, ev1, r2, ev2, d, im, c, f);
    endtask

    task automatic add_bubble(input string nm, input logic st);
        add(nm, st, 1'b1, 64'h114, 5'd3, 64'h3, 5'd4, 64'h4, 5'd5, 64'h5, 8'hFF, 4'hF,
            1'b1, 5'd3, 64'hBAD, 1'b0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0, 8'h00, 4'h0);
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; flush = v.flush; IF_ID_pc = v.pc; rs1 = v.rs1; rs1_value = v.v1;
        rs2 = v.rs2; rs2_value = v.v2; rd = v.rd; imm = v.imm; ctl = v.ctl; funct = v.funct;
        MEM_WB_RegWrite = v.wbwe; MEM_WB_rd = v.wbrd; writeback_mux_value = v.wbval;
    endtask

    task automatic check_vec(input vec_t v);
        chk({v.name, ".valid"}, 64'(ID_EX_valid), 64'(v.e_valid));
        chk({v.name, ".rs1"}, 64'(ID_EX_rs1), 64'(v.e_rs1));
        chk({v.name, ".rs2"}, 64'(ID_EX_rs2), 64'(v.e_rs2));
        chk({v.name, ".rd"}, 64'(ID_EX_rd), 64'(v.e_rd));
        if (v.e_valid) begin
            chk({v.name, ".pc"}, ID_EX_pc, v.e_pc);
            chk({v.name, ".v1"}, ID_EX_rs1_value, v.e_v1);
            chk({v.name, ".v2"}, ID_EX_rs2_value, v.e_v2);
            chk({v.name, ".imm"}, ID_EX_imm, v.e_imm);
            chk({v.name, ".ctl"}, 64'(out_ctl), 64'(v.e_ctl));
            chk({v.name, ".funct"}, 64'(ID_EX_funct), 64'(v.e_funct));
        end else begin
            // Bubble: RegWrite, MemRead, MemWrite, Branch, ALUOp must all be clear.
            chk({v.name, ".ctl"}, 64'(out_ctl & 8'hE7), 64'd0);
        end
    endtask

    initial begin
        logic [4:0] prev_rd;
        vec_t       v;

        reset = 1'b1;
        drive('{name: "idle", default: '0});

        // Held slot used by the stall/refresh sequence.
        add_load("bypass_rs1", 64'h100, 5'd5, 64'd10, 5'd6, 64'd20, 5'd7, 64'hFFFF_FFFF_FFFF_FFF0,
                 8'hA5, 4'h3, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd20);
        add_load("x0_nobypass", 64'h104, 5'd0, 64'd10, 5'd2, 64'd22, 5'd1, 64'd4, 8'h80, 4'h0,
                 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd10, 64'd22);
        add_load("wb_we0", 64'h108, 5'd9, 64'd33, 5'd9, 64'd44, 5'd2, 64'd8, 8'h4A, 4'h8,
                 1'b0, 5'd9, 64'hDEAD, 64'd33, 64'd44);
        add_load("bypass_both", 64'h10C, 5'd12, 64'd1, 5'd12, 64'd2, 5'd3, 64'd12, 8'hFF, 4'hF,
                 1'b1, 5'd12, 64'h55, 64'h55, 64'h55);
        add_load("bypass_rs2", 64'h110, 5'd13, 64'h13, 5'd14, 64'h14, 5'd4, 64'd0, 8'h90, 4'h1,
                 1'b1, 5'd14, 64'h99, 64'h13, 64'h99);
        add_bubble("flush", 1'b0);
        add_load("reload", 64'h118, 5'd1, 64'h11, 5'd2, 64'h22, 5'd3, 64'h30, 8'h80, 4'h2,
                 1'b0, 5'd0, 64'd0, 64'h11, 64'h22);
        add_bubble("flush_stall", 1'b1);
        add_load("slot_x", 64'h200, 5'd4, 64'h40, 5'd8, 64'h80, 5'd9, 64'h100, 8'h81, 4'h5,
                 1'b0, 5'd0, 64'd0, 64'h40, 64'h80);
        for (int i = 0; i < 3; i++) begin
            // Third stall writes x20, which matches the ID input rs1 but not the held rs1.
            add($sformatf("stall%0d", i), 1'b1, 1'b0, 64'h300 + 64'(i), 5'd20, 64'(i), 5'd21,
                64'(i), 5'd22, 64'hAAAA, 8'h7E, 4'hA, i == 2, 5'd20, 64'hEEEE,
                1'b1, 64'h200, 5'd4, 64'h40, 5'd8, 64'h80, 5'd9, 64'h100, 8'h81, 4'h5);
        end
        add("refresh_rs2", 1'b1, 1'b0, 64'h310, 5'd8, 64'd0, 5'd3, 64'd0, 5'd1, 64'd0, 8'hFF,
            4'h0, 1'b1, 5'd8, 64'h1234,
            1'b1, 64'h200, 5'd4, 64'h40, 5'd8, 64'h1234, 5'd9, 64'h100, 8'h81, 4'h5);
        add("refresh_rs1", 1'b1, 1'b0, 64'h314, 5'd8, 64'd0, 5'd3, 64'd0, 5'd1, 64'd0, 8'hFF,
            4'h0, 1'b1, 5'd4, 64'h77,
            1'b1, 64'h200, 5'd4, 64'h77, 5'd8, 64'h1234, 5'd9, 64'h100, 8'h81, 4'h5);
        add_load("release", 64'h400, 5'd15, 64'h150, 5'd16, 64'h160, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF,
                 8'h27, 4'h7, 1'b0, 5'd15, 64'd0, 64'h150, 64'h160);
        add_bubble("flush2", 1'b0);
        add("stall_bubble", 1'b1, 1'b0, 64'h500, 5'd6, 64'h6, 5'd7, 64'h7, 5'd8, 64'h8, 8'hFF,
            4'hF, 1'b1, 5'd6, 64'h66,
            1'b0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0, 8'h00, 4'h0);
        for (int i = 0; i < 4; i++) begin
            add_load($sformatf("b2b%0d", i), 64'h600 + 64'(4 * i), 5'(i + 1), 64'(16 * i + 1),
                     5'(i + 10), 64'(16 * i + 2), 5'(i + 20), 64'(i), 8'h80 | 8'(i), 4'(i),
                     1'b0, 5'd0, 64'd0, 64'(16 * i + 1), 64'(16 * i + 2));
        end

        #1 chk_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;
        prev_rd = 5'd0;

        foreach (vecs[k]) begin
            v = vecs[k];
            @(negedge clk);
            drive(v);
            #1 chk({v.name, ".pre_edge_rd"}, 64'(ID_EX_rd), 64'(prev_rd));
            @(posedge clk);
            #1 check_vec(v);
            prev_rd = v.e_rd;
        end

        // Async reset mid-stream: slot is valid, clear must land before the next edge.
        @(negedge clk);
        chk("pre_reset.valid", 64'(ID_EX_valid), 64'd1);
        #2 reset = 1'b1;
        #1 chk_zero("async_reset");
        @(posedge clk);
        #1 chk_zero("reset_held");
        @(negedge clk);
        reset = 1'b0;
        v = vecs[0];
        drive(v);
        @(posedge clk);
        #1 check_vec(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
